// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, BAUD_END sclk cycles per bit.
// Samples each bit at its centre, rejects start glitches and flags bad stop bits.
module uart_rx #(
    parameter int unsigned BAUD_END = 5208,
    parameter int unsigned BAUD_MID = BAUD_END / 2 - 1
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned CW = $clog2(BAUD_END);
    localparam logic [CW-1:0] CNT_MID = CW'(BAUD_MID);
    localparam logic [CW-1:0] CNT_END = CW'(BAUD_END - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          po_flag_q, po_flag_d;
    logic          frame_err_q, frame_err_d;
    logic          fall;
    logic          sample;
    logic [3:0]    bit_idx;

    assign fall    = !rx_s2_q && rx_s3_q;
    assign sample  = (baud_cnt_q == CNT_MID);
    assign bit_idx = bit_cnt_q - 4'd1;

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        po_flag_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            default: begin
                baud_cnt_d = (baud_cnt_q == CNT_END) ? '0 : baud_cnt_q + 1'b1;
                if (sample) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    case (state_q)
                        START: begin
                            if (rx_s2_q) begin
                                state_d   = IDLE;
                                bit_cnt_d = '0;
                            end else begin
                                state_d = DATA;
                            end
                        end
                        DATA: begin
                            shift_d[bit_idx[2:0]] = rx_s2_q;
                            if (bit_cnt_q == 4'd8) begin
                                state_d = STOP;
                            end
                        end
                        default: begin
                            // Leave at mid-stop so a back-to-back start edge is still seen.
                            if (rx_s2_q) begin
                                rx_data_d = shift_q;
                                po_flag_d = 1'b1;
                            end else begin
                                frame_err_d = 1'b1;
                            end
                            state_d   = IDLE;
                            bit_cnt_d = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            po_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_s1_q     <= rs232_rx;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            po_flag_q   <= po_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign po_flag   = po_flag_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8N1, LSB first, fixed baud derived from sclk; recovers bytes from the serial line rs232_rx.
- Sits at the receive side of the serial link, mirroring the transmitter.
- Presents each received byte on rx_data with a one-cycle po_flag strobe, for the command/loopback logic that feeds the transmitter's tx_flag/tx_data.
- Flags stop-bit (framing) errors and rejects glitch start bits.

Parameters:
- BAUD_END, 5208, sclk cycles per bit (50 MHz / 9600 baud); must be ≥ 4.
- BAUD_MID, BAUD_END/2 - 1, baud_cnt value at which a bit is sampled (bit centre).

Ports:
- sclk  input  1  system clock; all logic on rising edge.
- s_rst  input  1  reset, asynchronous, active-high.
- rs232_rx  input  1  serial line, asynchronous to sclk, idle high.
- rx_data  output  8  last correctly received byte.
- po_flag  output  1  one-cycle strobe: rx_data updated this cycle.
- frame_err  output  1  one-cycle strobe: byte dropped because its stop bit was 0.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

Behaviour:
- Clocking: single clock sclk; reset s_rst is asynchronous and active-high.
- Reset values: rx_data = 0, po_flag = 0, frame_err = 0, busy = 0, state = IDLE, counters = 0, sync flops = 1 (idle level, so no false edge on release).
- Synchroniser: rs232_rx → rx_s1 → rx_s2 → rx_s3.
  - Falling edge = (rx_s2 == 0 && rx_s3 == 1).
  - Only rx_s2 is sampled as bit data.
- baud_cnt (13 bits for the default):
  - Cleared in IDLE and in the cycle the falling edge is detected.
  - Otherwise increments each cycle, wrapping BAUD_END-1 → 0.
  - Sample point = baud_cnt == BAUD_MID.
- bit_cnt (4 bits): counts sample points within a frame.
  - 0 = start, 1..8 = data[0..7], 9 = stop.
  - Cleared on entering IDLE.
- FSM states IDLE, START, DATA, STOP:
  - IDLE → START on falling edge, detected in cycle D.
  - START, at sample point: rx_s2 == 1 → IDLE (glitch, no strobe, no error); rx_s2 == 0 → DATA.
  - DATA, at sample points 1..8: shift rx_s2 into shift register bit (bit_cnt-1). After sample 8 → STOP.
  - STOP, at sample point 9:
    - rx_s2 == 1: rx_data <= shift register, po_flag = 1 for the next cycle.
    - rx_s2 == 0: frame_err = 1 for the next cycle, rx_data unchanged.
    - Either way → IDLE. The return happens at mid-stop-bit, so a back-to-back start bit is caught.
- Timing: with detection cycle D, sample n (n = 0..9) occurs in cycle D+1+BAUD_MID+n*BAUD_END.
- Latency: po_flag/frame_err high exactly in cycle D+2+BAUD_MID+9*BAUD_END. Detection D is 2 sclk after the pin falls.
- po_flag and frame_err are mutually exclusive, never high two consecutive cycles, and never asserted in reset.
- busy = 1 from cycle D+1 until the cycle the strobe is issued (inclusive of the return to IDLE transition cycle only).
- Line activity during a frame: edges on rs232_rx while not in IDLE are ignored (no resynchronisation).
- Reset mid-frame: immediate return to reset values. The partial byte is discarded and no strobe is issued.
- Line held low (break): start passes, data all 0, stop is 0 → frame_err. FSM then waits in IDLE for a fresh falling edge; a continuously low line generates no further errors.

Test Plan:
- Reset release with line idle high, BAUD_END=16, BAUD_MID=7: no po_flag/frame_err for 500 cycles, rx_data = 0x00, busy = 0.
- Send 0xA5 (8N1, 16 cycles/bit) → single po_flag exactly 153 cycles after edge detection, rx_data = 0xA5, frame_err never high.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap → three po_flag pulses, rx_data sequence 0x00, 0xFF, 0x3C, no frame_err.
- Frame 0x55 with stop bit driven 0 → frame_err pulse at cycle D+153, no po_flag, rx_data keeps previous 0x3C; line then idles, no further strobes.
- 4-cycle low glitch on idle line → busy pulses, FSM returns to IDLE at start sample point, no strobes; following valid 0x81 received correctly.
- Assert s_rst during bit 4 of 0x96 → all outputs 0 immediately. After release, the remaining line activity must not produce a strobe unless a new falling edge begins a valid frame; the next full frame 0x12 is received correctly.
